mem_access_sequencer: RTL

MEM-stage load/store initiator that converts one pipeline memory request (byte, half-word or word) into a sequence of single-byte accesses on an 8-bit data-memory port. It sits between the EX/MEM pipeline register and the byte-addressed data memory. It drives a ready/done handshake so the pipeline stalls while the transfer is in flight. Byte order is big-endian: the lowest address holds the most-significant byte, consistent with the data RAM layout.

---
 rtl/mem_pkg.sv | 27 ++
 rtl/mem_access_sequencer_if.sv | 32 +++
 rtl/mem_load_extend.sv | 18 +
 rtl/mem_access_sequencer.sv | 131 +++++++++++++
 4 files changed

// File: rtl/mem_pkg.sv
// Shared encodings, FSM states and size helper for the MEM-stage byte sequencer.
package mem_pkg;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_ILL  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_e;

  // Byte count of a request; the illegal encoding maps to 0.
  function automatic logic [2:0] size_to_bytes(input logic [1:0] size);
    logic [2:0] n;
    case (size)
      SIZE_BYTE: n = 3'd1;
      SIZE_HALF: n = 3'd2;
      SIZE_WORD: n = 3'd4;
      default:   n = 3'd0;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/mem_access_sequencer_if.sv
// Pipeline request/response handshake plus the 8-bit data-memory port.
interface mem_access_sequencer_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              req_valid;
  logic              req_rw;
  logic [1:0]        req_size;
  logic              req_signed;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              ready;
  logic              done;
  logic              err;
  logic [31:0]       rdata;
  logic              mem_en;
  logic              mem_rw;
  logic [ADDR_W-1:0] mem_addr;
  logic [7:0]        mem_wdata;
  logic [7:0]        mem_rdata;

  // Pipeline plus memory environment side.
  modport master (
    output req_valid, req_rw, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    input  ready, done, err, rdata, mem_en, mem_rw, mem_addr, mem_wdata
  );

  // Sequencer side.
  modport slave (
    input  req_valid, req_rw, req_size, req_signed, req_addr, req_wdata, mem_rdata,
    output ready, done, err, rdata, mem_en, mem_rw, mem_addr, mem_wdata
  );
endinterface

// File: rtl/mem_load_extend.sv
// Sign/zero extension of the right-aligned load accumulator to 32 bits.
module mem_load_extend (
  input  logic [31:0] acc,
  input  logic [2:0]  n_bytes,
  input  logic        is_signed,
  output logic [31:0] result
);

  // Pick the sign bit of the top loaded byte and replicate it (or zero).
  always_comb begin
    case (n_bytes)
      3'd1:    result = {{24{is_signed & acc[7]}}, acc[7:0]};
      3'd2:    result = {{16{is_signed & acc[15]}}, acc[15:0]};
      default: result = acc;
    endcase
  end

endmodule

// File: rtl/mem_access_sequencer.sv
// Splits one byte/half/word load or store into big-endian single-byte accesses.
module mem_access_sequencer
  import mem_pkg::*;
#(
  parameter int unsigned ADDR_W    = 32,
  parameter int unsigned MEM_BYTES = 256
) (
  input logic             clk,
  input logic             reset,
  mem_access_sequencer_if.slave bus
);

  // One extra bit so addr + n near the top of the address space cannot wrap.
  localparam logic [ADDR_W:0] MemLimit = (ADDR_W+1)'(MEM_BYTES);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q;
  logic [2:0]        n_q;
  logic [1:0]        idx_q;
  logic              rw_q;
  logic              signed_q;
  logic [31:0]       wdata_q;
  logic [31:0]       acc_q;
  logic [31:0]       rdata_q;
  logic              err_q;

  logic [2:0]        req_n;
  logic [ADDR_W:0]   req_end;
  logic              req_legal;
  logic              accept;
  logic              start;
  logic [2:0]        n_m1;
  logic              last_byte;
  logic [1:0]        lane;
  logic [31:0]       ext_result;
  logic [31:0]       resp_data;

  assign req_n     = size_to_bytes(bus.req_size);
  assign req_end   = {1'b0, bus.req_addr} + (ADDR_W+1)'(req_n);
  assign accept    = (state_q == IDLE) && bus.req_valid;
  assign start     = accept && req_legal;
  assign n_m1      = n_q - 3'd1;
  assign last_byte = ({1'b0, idx_q} == n_m1);
  // Byte (n-1-idx) of the store data; mod-4 arithmetic covers n = 4.
  assign lane      = n_m1[1:0] - idx_q;
  assign resp_data = rw_q ? 32'd0 : ext_result;

  // Request legality: encoding, alignment and range.
  always_comb begin
    req_legal = 1'b1;
    if (bus.req_size == SIZE_ILL) req_legal = 1'b0;
    if (bus.req_size == SIZE_HALF && bus.req_addr[0]) req_legal = 1'b0;
    if (bus.req_size == SIZE_WORD && bus.req_addr[1:0] != 2'b00) req_legal = 1'b0;
    if (req_end > MemLimit) req_legal = 1'b0;
  end

  mem_load_extend u_load_extend (
    .acc       (acc_q),
    .n_bytes   (n_q),
    .is_signed (signed_q),
    .result    (ext_result)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = XFER;
      XFER:    if (last_byte) state_d = RESP;
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Request latch, byte counter, load accumulator and response hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q   <= '0;
      n_q      <= 3'd0;
      idx_q    <= 2'd0;
      rw_q     <= 1'b0;
      signed_q <= 1'b0;
      wdata_q  <= 32'd0;
      acc_q    <= 32'd0;
      rdata_q  <= 32'd0;
      err_q    <= 1'b0;
    end else begin
      err_q <= accept && !req_legal;
      if (start) begin
        addr_q   <= bus.req_addr;
        n_q      <= req_n;
        idx_q    <= 2'd0;
        rw_q     <= bus.req_rw;
        signed_q <= bus.req_signed;
        wdata_q  <= bus.req_wdata;
        acc_q    <= 32'd0;
        rdata_q  <= 32'd0;
      end else if (state_q == XFER) begin
        idx_q <= last_byte ? 2'd0 : idx_q + 2'd1;
        if (!rw_q) acc_q <= {acc_q[23:0], bus.mem_rdata};
      end else if (state_q == RESP) begin
        rdata_q <= resp_data;
      end
    end
  end

  // Handshake and memory-port outputs.
  always_comb begin
    bus.ready     = (state_q == IDLE);
    bus.done      = (state_q == RESP);
    bus.err       = err_q;
    bus.rdata     = (state_q == RESP) ? resp_data : rdata_q;
    bus.mem_en    = 1'b0;
    bus.mem_rw    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = 8'd0;
    if (state_q == XFER) begin
      bus.mem_en   = 1'b1;
      bus.mem_rw   = rw_q;
      bus.mem_addr = addr_q + ADDR_W'(idx_q);
      if (rw_q) bus.mem_wdata = wdata_q[{lane, 3'b000} +: 8];
    end
  end

endmodule
